// File: rtl/pixel_sink_fb_pkg.sv
// Shared definitions for the pixel sink: screen geometry, framebuffer
// address width, controller state encodings and the queued plot record.
package pixel_sink_fb_pkg;

   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int FB_ADDR_W = 15;

   // Controller states, kept as plain constants so older code can compare
   // against them directly.
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   // One queued plot: the pixel value and its already-linearised address.
   typedef struct packed {
      logic                 colour;
      logic [FB_ADDR_W-1:0] addr;
   } plot_entry_t;

   // Row-major linear address; w is a constant so the multiply folds into
   // shifts and adds.
   function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] px,
                                                    input logic [6:0] py,
                                                    input int w);
      return FB_ADDR_W'(py) * FB_ADDR_W'(w) + FB_ADDR_W'(px);
   endfunction

endpackage

// File: rtl/pixel_sink_fb_fifo.sv
// Small synchronous FIFO that buffers accepted plots until the framebuffer
// write port is free. Pushes while full and pops while empty are ignored.
module pixel_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              push_ok;
   logic              pop_ok;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage needs no reset; only the pointers and occupancy define contents.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; reset discards anything queued.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_sink_fb.sv
// Receiving end of the sprite plot stream: queues plots, writes them into a
// 1-bit framebuffer one per cycle, offers a registered read port and a
// full-screen sweep clear.
module pixel_sink_fb
   import pixel_sink_fb_pkg::*;
#(
   parameter int WIDTH      = SCREEN_W,
   parameter int HEIGHT     = SCREEN_H,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       plot,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic       colour,
   output logic       ready,
   input  logic       clear_req,
   output logic       clear_busy,
   input  logic       rd_en,
   input  logic [7:0] rd_x,
   input  logic [6:0] rd_y,
   output logic       rd_colour,
   output logic       rd_valid,
   output logic [7:0] drop_count
);

   localparam logic [7:0]           X_LIM     = 8'(WIDTH);
   localparam logic [6:0]           Y_LIM     = 7'(HEIGHT);
   localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(WIDTH*HEIGHT-1);

   logic                 fb [WIDTH*HEIGHT];
   logic [0:0]           state;
   logic [FB_ADDR_W-1:0] clr_addr;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 accept;
   logic                 in_range;
   logic                 push;
   logic                 pop;
   plot_entry_t          push_entry;
   plot_entry_t          head;
   logic                 wr_en;
   logic [FB_ADDR_W-1:0] wr_addr;
   logic                 wr_data;
   logic                 rd_in_range;
   logic [FB_ADDR_W-1:0] rd_addr;

   assign ready       = !fifo_full;
   assign clear_busy  = (state == CLEAR);
   assign accept      = plot && ready;
   assign in_range    = (x < X_LIM) && (y < Y_LIM);
   assign push        = accept && in_range;
   assign pop         = (state == IDLE) && !fifo_empty;
   assign push_entry  = '{colour: colour, addr: fb_addr(x, y, WIDTH)};
   assign rd_in_range = (rd_x < X_LIM) && (rd_y < Y_LIM);
   assign rd_addr     = fb_addr(rd_x, rd_y, WIDTH);

   pixel_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W ($bits(plot_entry_t))
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Controller: IDLE drains the queue, CLEAR sweeps every address once.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         clr_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clear_req) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
               end
            end
            CLEAR: begin
               if (clr_addr == LAST_ADDR) begin
                  state <= IDLE;
               end else begin
                  clr_addr <= clr_addr + FB_ADDR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Single write port shared between the sweep and the drained plots.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = head.addr;
      wr_data = head.colour;
      if (state == CLEAR) begin
         wr_en   = reset;
         wr_addr = clr_addr;
         wr_data = 1'b0;
      end else if (pop) begin
         wr_en = reset;
      end
   end

   // Framebuffer storage survives reset so a frame is not lost by it.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         fb[wr_addr] <= wr_data;
      end
   end

   // Registered read; a same-cycle write is seen only by later reads.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_colour <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_colour <= rd_in_range ? fb[rd_addr] : 1'b0;
         end
      end
   end

   // Saturating tally of plots that fell off the screen.
   always_ff @(posedge clock) begin
      if (!reset) begin
         drop_count <= '0;
      end else if (accept && !in_range && (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_pixel_sink_fb.sv
// Self-checking bench for pixel_sink_fb: directed steps plus randomized
// plots and reads checked against a flat per-pixel model of the screen.
module tb_pixel_sink_fb;

   logic       clock      = 1'b0;
   logic       reset      = 1'b0;
   logic       plot       = 1'b0;
   logic [7:0] x          = '0;
   logic [6:0] y          = '0;
   logic       colour     = 1'b0;
   logic       clear_req  = 1'b0;
   logic       rd_en      = 1'b0;
   logic [7:0] rd_x       = '0;
   logic [6:0] rd_y       = '0;
   logic       ready;
   logic       clear_busy;
   logic       rd_colour;
   logic       rd_valid;
   logic [7:0] drop_count;

   int total     = 0;
   int bad       = 0;
   int cyc       = 0;
   int clr_start = 0;
   int exp_drops = 0;
   bit model [0:19199];

   pixel_sink_fb dut (
      .clock      (clock),
      .reset      (reset),
      .plot       (plot),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .ready      (ready),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .rd_en      (rd_en),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_colour  (rd_colour),
      .rd_valid   (rd_valid),
      .drop_count (drop_count)
   );

   // Free-running clock and edge counter used to time the clear sweep.
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic p, input logic [7:0] px, input logic [6:0] py, input logic c);
      plot   = p;
      x      = px;
      y      = py;
      colour = c;
   endtask

   function automatic bit expPixel(input int px, input int py);
      if (px >= 160 || py >= 120) return 1'b0;
      return model[py*160 + px];
   endfunction

   // What an accepted plot does to the screen, in plain terms.
   task automatic modelPlot(input int px, input int py, input bit c);
      if (px < 160 && py < 120) model[py*160 + px] = c;
      else if (exp_drops < 255) exp_drops++;
   endtask

   task automatic sendPlot(input int px, input int py, input bit c);
      int guard = 0;
      bit done  = 1'b0;
      applyStimulus(1'b1, 8'(px), 7'(py), c);
      while (!done && guard < 64) begin
         done = (ready === 1'b1);
         step();
         guard++;
      end
      applyStimulus(1'b0, 8'd0, 7'd0, 1'b0);
      if (!done) checkOutput("plot_accept_timeout", 0, 1);
      else modelPlot(px, py, c);
   endtask

   task automatic readCheck(input string tag, input int px, input int py);
      rd_en = 1'b1;
      rd_x  = 8'(px);
      rd_y  = 7'(py);
      step();
      rd_en = 1'b0;
      checkOutput({tag, "_valid"}, 32'(rd_valid), 1);
      checkOutput(tag, 32'(rd_colour), 32'(expPixel(px, py)));
   endtask

   task automatic startClear();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      clr_start = cyc;
      for (int i = 0; i < 19200; i++) model[i] = 1'b0;
      checkOutput("clear_busy_rise", 32'(clear_busy), 1);
   endtask

   task automatic waitClear();
      int guard = 0;
      while (clear_busy === 1'b1 && guard < 20100) begin
         step();
         guard++;
      end
      if (clear_busy !== 1'b0) checkOutput("clear_timeout", 32'(clear_busy), 0);
      checkOutput("clear_length", 32'(cyc - clr_start), 19200);
   endtask

   initial begin
      int px [5];
      int py [5];
      int acc;
      int guard;
      bit ok;

      // Reset state
      reset = 1'b0;
      step();
      step();
      checkOutput("rst_ready", 32'(ready), 1);
      checkOutput("rst_clear_busy", 32'(clear_busy), 0);
      checkOutput("rst_rd_colour", 32'(rd_colour), 0);
      checkOutput("rst_rd_valid", 32'(rd_valid), 0);
      checkOutput("rst_drop_count", 32'(drop_count), 0);
      reset = 1'b1;
      step();

      // Corner pixel, then a clear with a stray request halfway through
      sendPlot(159, 119, 1'b1);
      step();
      readCheck("corner_set", 159, 119);
      startClear();
      repeat (5000) step();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      waitClear();
      readCheck("corner_cleared", 159, 119);
      readCheck("origin_cleared", 0, 0);

      // Basic write latency and a one-cycle read pulse
      sendPlot(3, 2, 1'b1);
      step();
      readCheck("pix_3_2", 3, 2);
      step();
      checkOutput("rd_valid_pulse", 32'(rd_valid), 0);
      readCheck("pix_4_2", 4, 2);

      // Read and write of the same pixel in the same cycle sees old data
      applyStimulus(1'b1, 8'd10, 7'd10, 1'b1);
      step();
      applyStimulus(1'b0, 8'd0, 7'd0, 1'b0);
      rd_en = 1'b1;
      rd_x  = 8'd10;
      rd_y  = 7'd10;
      step();
      rd_en = 1'b0;
      checkOutput("same_cycle_old", 32'(rd_colour), 0);
      model[10*160 + 10] = 1'b1;
      readCheck("same_cycle_next", 10, 10);

      // Randomized in-range plots followed by random reads
      for (int i = 0; i < 40; i++) begin
         sendPlot($urandom_range(159, 0), $urandom_range(119, 0), 1'($urandom_range(1, 0)));
      end
      repeat (6) step();
      for (int i = 0; i < 30; i++) begin
         readCheck("rand_rd", $urandom_range(255, 0), $urandom_range(127, 0));
      end
      readCheck("rand_hit", 3, 2);

      // Plots held continuously during a clear fill the queue and survive
      px = '{20, 21, 22, 100, 7};
      py = '{30, 30, 31, 50, 99};
      startClear();
      acc   = 0;
      guard = 0;
      while (acc < 5 && guard < 40) begin
         applyStimulus(1'b1, 8'(px[acc]), 7'(py[acc]), 1'b1);
         ok = ready;
         step();
         if (ok) begin
            modelPlot(px[acc], py[acc], 1'b1);
            acc++;
         end
         guard++;
      end
      checkOutput("accepted_in_clear", 32'(acc), 4);
      checkOutput("ready_when_full", 32'(ready), 0);
      applyStimulus(1'b0, 8'd0, 7'd0, 1'b0);
      waitClear();
      repeat (6) step();
      for (int i = 0; i < 5; i++) readCheck("clear_survivor", px[i], py[i]);
      for (int i = 0; i < 10; i++) begin
         readCheck("post_clear_rd", $urandom_range(159, 0), $urandom_range(119, 0));
      end

      // Off-screen plots are consumed and counted, saturating at 255
      sendPlot(160, 0, 1'b1);
      sendPlot(0, 120, 1'b1);
      step();
      checkOutput("drop_two", 32'(drop_count), 2);
      readCheck("drop_no_write", 0, 0);
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) sendPlot($urandom_range(255, 160), $urandom_range(127, 0), 1'b1);
         else sendPlot($urandom_range(159, 0), $urandom_range(127, 120), 1'b1);
      end
      step();
      checkOutput("drop_saturate", 32'(drop_count), 32'(exp_drops));
      checkOutput("drop_255", 32'(drop_count), 255);

      // Reset partway through a clear aborts it and discards queued plots
      sendPlot(120, 118, 1'b1);
      sendPlot(50, 0, 1'b1);
      sendPlot(5, 5, 1'b0);
      repeat (6) step();
      readCheck("pix_19000_set", 120, 118);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      clr_start = cyc;
      applyStimulus(1'b1, 8'd5, 7'd5, 1'b1);
      ok = ready;
      step();
      applyStimulus(1'b0, 8'd0, 7'd0, 1'b0);
      checkOutput("pending_accepted", 32'(ok), 1);
      while (cyc - clr_start < 100) step();
      reset = 1'b0;
      step();
      checkOutput("abort_clear_busy", 32'(clear_busy), 0);
      checkOutput("abort_ready", 32'(ready), 1);
      checkOutput("abort_drop_count", 32'(drop_count), 0);
      reset = 1'b1;
      exp_drops = 0;
      for (int i = 0; i < 90; i++) model[i] = 1'b0;
      repeat (6) step();
      readCheck("abort_19000_kept", 120, 118);
      readCheck("abort_early_cleared", 50, 0);
      readCheck("abort_pending_dropped", 5, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
